// File: rtl/rs232_tx_arbiter_if.sv
// Requester/transmitter bundle around the shared RS232 TX arbiter.
// The master side is the environment (producers plus TX core); the slave side is the arbiter.
interface rs232_tx_arbiter_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic [N-1:0]   ack;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           busy;

  modport master (
    output req, data, tx_busy,
    input  ack, tx_start, tx_data, grant_id, busy
  );

  modport slave (
    input  req, data, tx_busy,
    output ack, tx_start, tx_data, grant_id, busy
  );
endinterface

// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter sharing one byte-level RS232 transmitter among N requesters.
// Optional RS232_ARB_TAG_EN: prefix every granted byte with a tag frame 8'hF0|grant_id.
module rs232_tx_arbiter #(
  parameter int unsigned N          = 4,
  parameter int unsigned GAP_CYCLES = 16
) (
  input logic               clk,
  input logic               rst_n,
  rs232_tx_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = 2;
  localparam int unsigned GAP_W = 8;
  localparam int unsigned MAX_N = 4;

`ifdef RS232_ARB_TAG_EN
  typedef enum logic [2:0] {IDLE, ACCEPT, SEND, GAP, TAG} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCEPT, SEND, GAP} state_t;
`endif

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   sel;
  logic               sel_valid;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [MAX_N-1:0]   ack_q, ack_d;
  logic [MAX_N-1:0]   req4;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [PTR_W-1:0]   ptr_after_grant;
  logic [7:0]         req_byte [MAX_N];
`ifdef RS232_ARB_TAG_EN
  logic [7:0]         hold_q, hold_d;
  logic               tag_phase_q, tag_phase_d;
`endif

  // Widen to four lanes so the 2-bit indices always land inside the arrays.
  assign req4 = MAX_N'(bus.req);

  for (genvar g = 0; g < int'(MAX_N); g++) begin : g_lane
    if (g < int'(N)) begin : g_used
      assign req_byte[g] = bus.data[8*g +: 8];
    end else begin : g_unused
      assign req_byte[g] = 8'h00;
    end
  end

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    logic [PTR_W:0] idx;
    sel       = '0;
    sel_valid = 1'b0;
    idx       = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = {1'b0, ptr_q} + (PTR_W+1)'(off);
      if (idx >= (PTR_W+1)'(N)) idx = idx - (PTR_W+1)'(N);
      if (!sel_valid && req4[idx[PTR_W-1:0]]) begin
        sel_valid = 1'b1;
        sel       = idx[PTR_W-1:0];
      end
    end
  end

  assign ptr_after_grant = (grant_q == PTR_W'(N - 1)) ? '0 : grant_q + PTR_W'(1);

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    gap_d      = gap_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
`ifdef RS232_ARB_TAG_EN
    hold_d      = hold_q;
    tag_phase_d = tag_phase_q;
`endif

    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          grant_d    = sel;
          ack_d[sel] = 1'b1;
          tx_start_d = 1'b1;
`ifdef RS232_ARB_TAG_EN
          tx_data_d   = 8'hF0 | 8'(sel);
          hold_d      = req_byte[sel];
          tag_phase_d = 1'b1;
`else
          tx_data_d   = req_byte[sel];
`endif
          state_d    = ACCEPT;
        end
      end
      ACCEPT: begin
        if (bus.tx_busy) state_d = SEND;
      end
      SEND: begin
        if (!bus.tx_busy) begin
`ifdef RS232_ARB_TAG_EN
          if (tag_phase_q) begin
            tx_start_d  = 1'b1;
            tx_data_d   = hold_q;
            tag_phase_d = 1'b0;
            state_d     = TAG;
          end else
`endif
          begin
            gap_d   = GAP_W'(GAP_CYCLES);
            ptr_d   = ptr_after_grant;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) state_d = IDLE;
      end
`ifdef RS232_ARB_TAG_EN
      // Data-byte start cycle; a core that goes busy at once skips ACCEPT.
      TAG: begin
        state_d = bus.tx_busy ? SEND : ACCEPT;
      end
`endif
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      gap_q      <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
`ifdef RS232_ARB_TAG_EN
      hold_q      <= 8'h00;
      tag_phase_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      gap_q      <= gap_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
`ifdef RS232_ARB_TAG_EN
      hold_q      <= hold_d;
      tag_phase_q <= tag_phase_d;
`endif
    end
  end

  assign bus.ack      = ack_q[N-1:0];
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Scoreboard bench for rs232_tx_arbiter: queued requesters, a transmitter model and a
// transaction-level round-robin model predicting grant order and frame bytes.
module tb_rs232_tx_arbiter;
  localparam int N   = 4;
  localparam int GAP = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  rs232_tx_arbiter_if #(.N(N)) bus ();

  rs232_tx_arbiter #(.N(N), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef logic [7:0] bq_t[$];
  bq_t        rq    [N];
  bq_t        stage [N];
  int         req_rise_cyc [N];
  int         grant_q[$];
  logic [7:0] frame_q[$];
  int         model_ptr = 0;
  int         tx_len_fixed = 0;
  int         tx_dly_fixed = -1;
  int         busy_fall_cyc = 0;

  // Requester side: present the head of each queue, pop on ack.
  initial begin
    bus.req  = '0;
    bus.data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < N; i++) rq[i].delete();
        bus.req = '0;
        continue;
      end
      for (int i = 0; i < N; i++) begin
        if (bus.ack[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        if (rq[i].size() != 0) begin
          if (!bus.req[i]) req_rise_cyc[i] = cyc;
          bus.req[i]          = 1'b1;
          bus.data[8*i +: 8]  = rq[i][0];
        end else begin
          bus.req[i]          = 1'b0;
          bus.data[8*i +: 8]  = 8'($urandom);
        end
      end
    end
  end

  // Transmitter model: random start delay and frame length; checks bytes and stability.
  initial begin
    int         phase, rem, dly, held_bad;
    logic [7:0] cur;
    phase = 0; rem = 0; dly = 0; held_bad = 0; cur = '0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.tx_busy = 1'b0;
        phase = 0;
        continue;
      end
      if (phase != 0 && bus.tx_start)
        check(1'b0, "tx_start_while_core_busy", 1, 0);
      case (phase)
        0: if (bus.tx_start) begin
          cur = bus.tx_data;
          if (frame_q.size() == 0) check(1'b0, "frame_unexpected", int'(cur), -1);
          else begin
            logic [7:0] e;
            e = frame_q.pop_front();
            check(cur == e, "frame_byte", int'(cur), int'(e));
          end
          held_bad = 0;
          rem = (tx_len_fixed > 0) ? tx_len_fixed : int'($urandom_range(1, 12));
          dly = (tx_dly_fixed >= 0) ? tx_dly_fixed : int'($urandom_range(0, 2));
          if (dly == 0) begin bus.tx_busy = 1'b1; phase = 2; end
          else phase = 1;
        end
        1: begin
          dly--;
          if (bus.tx_data != cur) held_bad++;
          if (dly == 0) begin bus.tx_busy = 1'b1; phase = 2; end
        end
        default: begin
          if (bus.tx_data != cur) held_bad++;
          rem--;
          if (rem == 0) begin
            check(held_bad == 0, "tx_data_held", held_bad, 0);
            bus.tx_busy   = 1'b0;
            busy_fall_cyc = cyc;
            phase         = 0;
          end
        end
      endcase
    end
  end

  // Grant monitor: ack shape, grant order and pulse spacing.
  initial begin
    bit prev_ack, prev_start;
    prev_ack = 1'b0; prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin prev_ack = 1'b0; prev_start = 1'b0; continue; end
      if (bus.ack != '0) begin
        check($onehot(bus.ack), "ack_onehot", int'(bus.ack), 1);
        check(!prev_ack, "ack_consecutive", int'(prev_ack), 0);
        if (grant_q.size() == 0) check(1'b0, "ack_unexpected", int'(bus.ack), 0);
        else begin
          int e;
          e = grant_q.pop_front();
          check(bus.ack == 4'(1 << e), "ack_id", int'(bus.ack), 1 << e);
          check(bus.grant_id == 2'(e), "grant_id", int'(bus.grant_id), e);
        end
      end
      if (bus.tx_start) check(!prev_start, "tx_start_consecutive", int'(prev_start), 0);
      prev_ack   = (bus.ack != '0);
      prev_start = bus.tx_start;
    end
  end

  // Round-robin reference over whole byte queues; every queue is pending at each decision.
  task automatic issue();
    bq_t m [N];
    int  left;
    left = 0;
    for (int i = 0; i < N; i++) begin
      m[i] = stage[i];
      left += m[i].size();
    end
    while (left > 0) begin
      for (int off = 0; off < N; off++) begin
        int idx;
        idx = (model_ptr + off) % N;
        if (m[idx].size() != 0) begin
          logic [7:0] b;
          b = m[idx].pop_front();
          grant_q.push_back(idx);
`ifdef RS232_ARB_TAG_EN
          frame_q.push_back(8'hF0 | 8'(idx));
`endif
          frame_q.push_back(b);
          model_ptr = (idx + 1) % N;
          left--;
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      foreach (stage[i][k]) rq[i].push_back(stage[i][k]);
      stage[i].delete();
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int  n;
    bit  pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < budget) begin
      @(negedge clk);
      n++;
      pending = (frame_q.size() != 0) || bus.busy;
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) pending = 1'b1;
    end
    check(n < budget, name, n, budget);
    check(grant_q.size() == 0, "grants_left_over", grant_q.size(), 0);
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.ack == '0 && n < 100);
    check(n < 100, name, n, 100);
  endtask

  task automatic check_reset_outputs();
    check(bus.ack == '0, "rst_ack", int'(bus.ack), 0);
    check(bus.tx_start == 1'b0, "rst_tx_start", int'(bus.tx_start), 0);
    check(bus.tx_data == 8'h00, "rst_tx_data", int'(bus.tx_data), 0);
    check(bus.grant_id == 2'd0, "rst_grant_id", int'(bus.grant_id), 0);
    check(bus.busy == 1'b0, "rst_busy", int'(bus.busy), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Single request: latency, byte and idle gap length.
    tx_len_fixed = 10;
    tx_dly_fixed = 1;
    stage[0] = '{8'h41};
    issue();
    wait_ack("single_ack_timeout");
    check(cyc - req_rise_cyc[0] == 1, "ack_latency", cyc - req_rise_cyc[0], 1);
    check(bus.tx_start == 1'b1, "tx_start_with_ack", int'(bus.tx_start), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.busy && n < 300);
    check(n < 300, "busy_drop_timeout", n, 300);
    check(cyc - busy_fall_cyc == GAP + 1, "gap_length", cyc - busy_fall_cyc, GAP + 1);
    tx_len_fixed = 0;
    tx_dly_fixed = -1;

    // All four requesting continuously.
    for (int i = 0; i < N; i++) stage[i] = '{8'(8'h10 + i), 8'(8'h10 + i)};
    issue();
    wait_done("all_four_timeout", 3000);

    // Fairness: requester 0 held, requester 2 pending once.
    stage[0] = '{8'hA0, 8'hA1, 8'hA2};
    stage[2] = '{8'hC2};
    issue();
    wait_done("fairness_timeout", 3000);

    // Randomised rounds.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) begin
        int cnt;
        cnt = int'($urandom_range(0, 3));
        for (int k = 0; k < cnt; k++) stage[i].push_back(8'($urandom));
      end
      issue();
      wait_done("random_round_timeout", 5000);
    end

    // Reset in the middle of a frame, then a clean grant to requester 2.
    tx_len_fixed = 20;
    stage[1] = '{8'hA5};
    issue();
    wait_ack("pre_reset_ack_timeout");
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    grant_q.delete();
    frame_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_reset_outputs();
    end
    rst_n = 1'b1;
    model_ptr = 0;
    tx_len_fixed = 0;
    @(negedge clk);
    @(negedge clk);
    stage[2] = '{8'h3C};
    issue();
    wait_done("post_reset_timeout", 3000);
    check(bus.grant_id == 2'd2, "post_reset_grant_id", int'(bus.grant_id), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
